// File: rtl/renkon_ctrl_conv.sv
// Convolution sequencer: per input channel, loads the filter weights and then streams the image.
// It also produces pipeline-aligned result strobes and output-buffer addresses.
module renkon_ctrl_conv #(
    parameter int unsigned MEMWIDTH = 12,
    parameter int unsigned LWIDTH   = 10,
    parameter int unsigned CONV_LAT = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic [LWIDTH-1:0]   img_size,
    input  logic [LWIDTH-1:0]   fil_size,
    input  logic [LWIDTH-1:0]   total_in,
    input  logic [MEMWIDTH-1:0] img_base,
    input  logic [MEMWIDTH-1:0] w_base,
    output logic                busy,
    output logic                ack,
    output logic                wreg_we,
    output logic [MEMWIDTH-1:0] w_addr,
    output logic                img_re,
    output logic [MEMWIDTH-1:0] img_addr,
    output logic                out_valid,
    output logic                out_first,
    output logic                out_last,
    output logic [MEMWIDTH-1:0] out_addr
);

    localparam int unsigned DW = (CONV_LAT > 1) ? $clog2(CONV_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WLOAD,
        S_CONV,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [LWIDTH-1:0]   r_img_size;
    logic [LWIDTH-1:0]   r_fil_size;
    logic [LWIDTH-1:0]   r_last_ch;
    logic [LWIDTH-1:0]   r_ch;
    logic [LWIDTH-1:0]   r_kx;
    logic [LWIDTH-1:0]   r_ky;
    logic [LWIDTH-1:0]   r_x;
    logic [LWIDTH-1:0]   r_y;
    logic                r_first_pend;
    logic [DW-1:0]       r_drain;
    logic                r_busy;
    logic                r_ack;
    logic                r_wreg_we;
    logic [MEMWIDTH-1:0] r_w_addr;
    logic                r_img_re;
    logic [MEMWIDTH-1:0] r_img_addr;
    logic [MEMWIDTH-1:0] r_out_addr;
    logic [CONV_LAT-1:0] r_vld;
    logic [CONV_LAT-1:0] r_fst;
    logic [CONV_LAT-1:0] r_lst;

    logic [LWIDTH-1:0]   w_fil_m1;
    logic [LWIDTH-1:0]   w_img_m1;
    logic                w_k_row_end;
    logic                w_k_last;
    logic                w_x_last;
    logic                w_y_last;
    logic                w_ch_last;
    logic                w_win;
    logic                w_fch;
    logic                w_lch;
    logic                w_nch;
    logic                w_nch_pre;
    logic [CONV_LAT:0]   w_vld_chain;
    logic [CONV_LAT:0]   w_fst_chain;
    logic [CONV_LAT:0]   w_lst_chain;

    assign w_fil_m1    = r_fil_size - LWIDTH'(1);
    assign w_img_m1    = r_img_size - LWIDTH'(1);
    assign w_k_row_end = (r_kx == w_fil_m1);
    assign w_k_last    = w_k_row_end && (r_ky == w_fil_m1);
    assign w_x_last    = (r_x == w_img_m1);
    assign w_y_last    = (r_y == w_img_m1);
    assign w_ch_last   = (r_ch == r_last_ch);

    // Pixel currently being read completes a full filter window
    assign w_win = r_img_re && (r_x >= w_fil_m1) && (r_y >= w_fil_m1);
    assign w_fch = w_win && (r_ch == '0);
    assign w_lch = w_win && w_ch_last;
    assign w_nch = w_win && r_first_pend;

    assign w_vld_chain = {r_vld, w_win};
    assign w_fst_chain = {r_fst, w_fch};
    assign w_lst_chain = {r_lst, w_lch};

    assign busy      = r_busy;
    assign ack       = r_ack;
    assign wreg_we   = r_wreg_we;
    assign w_addr    = r_w_addr;
    assign img_re    = r_img_re;
    assign img_addr  = r_img_addr;
    assign out_valid = w_vld_chain[CONV_LAT];
    assign out_first = w_fst_chain[CONV_LAT];
    assign out_last  = w_lst_chain[CONV_LAT];
    assign out_addr  = r_out_addr;

    // Window/channel flags travel alongside the datapath latency
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            r_fst <= '0;
            r_lst <= '0;
        end else begin
            r_vld <= w_vld_chain[CONV_LAT-1:0];
            r_fst <= w_fst_chain[CONV_LAT-1:0];
            r_lst <= w_lst_chain[CONV_LAT-1:0];
        end
    end

    // First-result-of-channel marker, taken one stage before the output
    generate
        if (CONV_LAT == 1) begin : g_nch_direct
            assign w_nch_pre = w_nch;
        end else begin : g_nch_pipe
            logic [CONV_LAT-2:0] r_nch;
            logic [CONV_LAT-1:0] w_nch_chain;
            assign w_nch_chain = {r_nch, w_nch};
            assign w_nch_pre   = w_nch_chain[CONV_LAT-1];
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_nch <= '0;
                end else begin
                    r_nch <= w_nch_chain[CONV_LAT-2:0];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_addr <= '0;
        end else if (w_nch_pre) begin
            r_out_addr <= '0;
        end else if (w_vld_chain[CONV_LAT]) begin
            r_out_addr <= r_out_addr + MEMWIDTH'(1);
        end
    end

    // Sequencer; address registers run continuously so each channel base is a running sum
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_img_size   <= '0;
            r_fil_size   <= '0;
            r_last_ch    <= '0;
            r_ch         <= '0;
            r_kx         <= '0;
            r_ky         <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_first_pend <= 1'b0;
            r_drain      <= '0;
            r_busy       <= 1'b0;
            r_ack        <= 1'b0;
            r_wreg_we    <= 1'b0;
            r_w_addr     <= '0;
            r_img_re     <= 1'b0;
            r_img_addr   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_img_size <= (img_size == '0) ? LWIDTH'(1) : img_size;
                        r_fil_size <= (fil_size == '0) ? LWIDTH'(1) : fil_size;
                        r_last_ch  <= (total_in == '0) ? '0 : total_in - LWIDTH'(1);
                        r_w_addr   <= w_base;
                        r_img_addr <= img_base;
                        r_ch       <= '0;
                        r_kx       <= '0;
                        r_ky       <= '0;
                        r_busy     <= 1'b1;
                        r_wreg_we  <= 1'b1;
                        r_state    <= S_WLOAD;
                    end
                end

                S_WLOAD: begin
                    r_w_addr <= r_w_addr + MEMWIDTH'(1);
                    if (w_k_last) begin
                        r_wreg_we    <= 1'b0;
                        r_img_re     <= 1'b1;
                        r_x          <= '0;
                        r_y          <= '0;
                        r_first_pend <= 1'b1;
                        r_state      <= S_CONV;
                    end else if (w_k_row_end) begin
                        r_kx <= '0;
                        r_ky <= r_ky + LWIDTH'(1);
                    end else begin
                        r_kx <= r_kx + LWIDTH'(1);
                    end
                end

                S_CONV: begin
                    r_img_addr <= r_img_addr + MEMWIDTH'(1);
                    if (w_win) begin
                        r_first_pend <= 1'b0;
                    end
                    if (w_x_last) begin
                        r_x <= '0;
                        if (w_y_last) begin
                            r_img_re <= 1'b0;
                            if (w_ch_last) begin
                                r_drain <= '0;
                                r_state <= S_DRAIN;
                            end else begin
                                r_ch      <= r_ch + LWIDTH'(1);
                                r_kx      <= '0;
                                r_ky      <= '0;
                                r_wreg_we <= 1'b1;
                                r_state   <= S_WLOAD;
                            end
                        end else begin
                            r_y <= r_y + LWIDTH'(1);
                        end
                    end else begin
                        r_x <= r_x + LWIDTH'(1);
                    end
                end

                S_DRAIN: begin
                    if (r_drain == DW'(CONV_LAT - 1)) begin
                        r_ack   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_drain <= r_drain + DW'(1);
                    end
                end

                S_DONE: begin
                    r_ack   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
